cdc_event_arbiter: RTL
======================

CDC_EVENT_ARBITER -- requirements
Module: cdc_event_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of asynchronous requesters (2..8).
REQ-002 The block SHALL have parameter STAGES, default 2, meaning the synchronizer depth per request line (>=2).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum BUSY cycles before abort (1..65535).
REQ-004 Port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port async_req, input, N: request levels from foreign domains; a rising edge on bit i is one event.
REQ-007 Port grant_valid, output, 1: a grant is offered.
REQ-008 Port grant_id, output, 3: the index of the granted requester, valid while grant_valid is high.
REQ-009 Port grant_ready, input, 1: the shared resource accepts the grant.
REQ-010 Port svc_done, input, 1: a single-cycle pulse, service of the accepted grant finished.
REQ-011 Port ack_toggle, output, N: bit i flips once per completed or aborted service of requester i, for return to its domain.
REQ-012 Port overflow, output, N: sticky flag, an event for requester i was lost.
REQ-013 Port timeout_err, output, 1: sticky flag, a service was aborted by timeout.
REQ-014 Port flag_clr, input, 1: clears overflow and timeout_err.

Function
REQ-015 Each async_req bit SHALL pass through a STAGES-deep flip-flop chain; the rising-edge pulse SHALL be the chain output AND NOT a one-cycle-delayed copy of it.
REQ-016 Edge pulses SHALL be suppressed for STAGES+1 cycles after rst deasserts (startup counter), so inputs already high at reset produce no event.
REQ-017 An edge pulse on bit i SHALL set pending[i] on the next clock edge.
REQ-018 Latency: with the input rising before sampling edge 1 and the FSM in IDLE, grant_valid SHALL go high after edge STAGES+2.
REQ-019 FSM states: IDLE, GRANT, BUSY.
REQ-020 IDLE -> GRANT when any pending bit is set; grant_id SHALL be latched by round-robin starting at index last_served+1 mod N.
REQ-021 GRANT: grant_valid=1, grant_id stable; on grant_valid&grant_ready, pending[grant_id] SHALL clear, last_served<=grant_id, and the FSM SHALL enter BUSY.
REQ-022 grant_valid SHALL NOT drop and grant_id SHALL NOT change in GRANT until accepted.
REQ-023 BUSY: a 16-bit counter increments from 0; on svc_done the FSM SHALL return to IDLE and toggle ack_toggle[grant_id].
REQ-024 BUSY: if the counter reaches TIMEOUT with no svc_done, the FSM SHALL return to IDLE, toggle ack_toggle[grant_id], and set timeout_err.
REQ-025 svc_done and timeout on the same cycle SHALL be treated as done (no timeout_err).
REQ-026 svc_done outside BUSY SHALL be ignored.
REQ-027 An edge pulse on i while pending[i]=1 and not being cleared that cycle SHALL set overflow[i]; pending stays 1.
REQ-028 An edge pulse on i in the same cycle as pending[i] clears SHALL leave pending[i]=1 with no overflow.
REQ-029 flag_clr SHALL clear the flags; a set event in the same cycle SHALL win.
REQ-030 The minimum IDLE dwell SHALL be one cycle between services.

Reset
REQ-031 While rst is high, the synchronizer chains, delayed copies, pending, overflow, timeout_err, ack_toggle, counter and grant_valid SHALL be 0, grant_id SHALL be 0, last_served SHALL be N-1, the FSM SHALL be in IDLE, and the startup counter SHALL be reloaded.
REQ-032 rst asserted mid-GRANT or mid-BUSY SHALL abort with no ack_toggle flip; the grant is lost.

Verification
REQ-033 N=4, STAGES=2: pulse async_req[2] high at cycle 10 -> grant_valid=1, grant_id=2 after edge 14; grant_ready=1 -> BUSY; svc_done -> ack_toggle=4'b0100.
REQ-034 Raise async_req[0], [1] and [3] simultaneously from reset -> grants in the order 0, 1, 3; after 3, a new [0] event is granted before [1].
REQ-035 Hold async_req=4'b1111 through reset -> no grants, pending stays 0 for 100 cycles.
REQ-036 Two edges on [1] while granted-but-unaccepted -> overflow=4'b0010; flag_clr -> 0.
REQ-037 TIMEOUT=5, accept a grant, withhold svc_done -> IDLE after 5 BUSY cycles, timeout_err=1, ack bit toggles.
REQ-038 Assert rst during BUSY -> all outputs 0 on the next edge, ack_toggle unchanged from 0.

Source files
------------

// File: rtl/cdc_event_arbiter.sv
// Synchronises N asynchronous request lines, turns their rising edges into pending events and
// serves those events one at a time, round-robin, through a grant / busy / done handshake.
module cdc_event_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] async_req,
    output logic         grant_valid,
    output logic [2:0]   grant_id,
    input  logic         grant_ready,
    input  logic         svc_done,
    output logic [N-1:0] ack_toggle,
    output logic [N-1:0] overflow,
    output logic         timeout_err,
    input  logic         flag_clr
);

    localparam int unsigned IDW = 3;
    localparam int unsigned CW  = 16;
    localparam int unsigned NW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUW = $clog2(STAGES + 2);
    localparam logic [SUW-1:0] SU_LOAD = SUW'(STAGES + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    logic [STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0]             sync_dly;
    logic [SUW-1:0]           startup_q;
    logic [N-1:0]             edge_c;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] grant_id_d;
    logic           grant_valid_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   ack_d;
    logic [N-1:0]   overflow_d;
    logic           timeout_err_d;
    logic [N-1:0]   gnt_oh_c;
    logic [N-1:0]   clr_c;
    logic           to_set_c;
    logic           found;
    int             idx;

    // Synchroniser chains, one-cycle delayed copy and post-reset edge blanking
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            sync_dly  <= '0;
            startup_q <= SU_LOAD;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], async_req};
            sync_dly <= sync_q[STAGES-1];
            if (startup_q != '0) begin
                startup_q <= startup_q - SUW'(1);
            end
        end
    end

    assign edge_c   = (startup_q == '0) ? (sync_q[STAGES-1] & ~sync_dly) : '0;
    assign gnt_oh_c = {{(N-1){1'b0}}, 1'b1} << grant_id;

    // Next-state, round-robin pick and flag update
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id;
        last_d     = last_q;
        cnt_d      = cnt_q;
        ack_d      = ack_toggle;
        clr_c      = '0;
        to_set_c   = 1'b0;
        found      = 1'b0;
        idx        = 0;

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d = GRANT;
                    for (int k = 1; k <= int'(N); k++) begin
                        idx = int'(last_q) + k;
                        if (idx >= int'(N)) begin
                            idx = idx - int'(N);
                        end
                        if (!found && pending_q[idx[NW-1:0]]) begin
                            found      = 1'b1;
                            grant_id_d = IDW'(idx);
                        end
                    end
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    clr_c   = gnt_oh_c;
                    last_d  = grant_id;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // done has priority over a timeout landing on the same cycle
                if (svc_done) begin
                    ack_d   = ack_toggle ^ gnt_oh_c;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    ack_d    = ack_toggle ^ gnt_oh_c;
                    to_set_c = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pending_d     = (pending_q & ~clr_c) | edge_c;
        overflow_d    = (flag_clr ? '0 : overflow) | (edge_c & pending_q & ~clr_c);
        timeout_err_d = (flag_clr ? 1'b0 : timeout_err) | to_set_c;
        grant_valid_d = (state_d == GRANT);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            last_q      <= IDW'(N - 1);
            grant_id    <= '0;
            grant_valid <= 1'b0;
            cnt_q       <= '0;
            ack_toggle  <= '0;
            overflow    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            grant_id    <= grant_id_d;
            grant_valid <= grant_valid_d;
            cnt_q       <= cnt_d;
            ack_toggle  <= ack_d;
            overflow    <= overflow_d;
            timeout_err <= timeout_err_d;
        end
    end

endmodule
